// File: rtl/irq_stim_gen_pkg.sv
// Shared types for the interrupt stimulus generator.
//   irq_mode_t  : per-channel behaviour (off, fixed-width pulse, level held until ack)
//   gen_state_t : reset sequencer state
//   ch_width()  : index width for a channel count, never zero
package irq_stim_gen_pkg;

  typedef enum logic [1:0] {
    IRQ_OFF   = 2'd0,
    IRQ_PULSE = 2'd1,
    IRQ_LEVEL = 2'd2
  } irq_mode_t;

  typedef enum logic {
    GEN_RESET = 1'b0,
    GEN_RUN   = 1'b1
  } gen_state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_stim_channel.sv
// One interrupt channel: holds its mode/period, counts down to the next fire
// event and shapes the line as a pulse or as a level held until acknowledged.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   run_i            generator is in RUN; counting and firing only happen then
//   clear_i          restart: drop line, pulse and overrun, reload the counter
//   cfg_we_i         write strobe already decoded for this channel
//   cfg_mode_i       new mode
//   cfg_period_i     new period (0 disables the channel)
//   ack_i            acknowledge already decoded for this channel
//   irq_o            interrupt line
//   overrun_o        sticky: LEVEL fire while the line was still pending
module irq_stim_channel
  import irq_stim_gen_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int PULSE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic             cfg_we_i,
  input  irq_mode_t        cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic             overrun_o
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);

  irq_mode_t        mode_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    pcnt_q;
  logic             irq_q;
  logic             ovr_q;

  logic active;
  logic fire;
  logic ovr_set;

  // The counter is loaded with the period, so reaching 1 means the next edge
  // is exactly `period` cycles after the load. An ack arriving with a fire
  // loses to the fire and does not count as an overrun.
  always_comb begin
    active  = run_i && (mode_q != IRQ_OFF) && (period_q != '0);
    fire    = active && (cnt_q <= CNT_W'(1));
    ovr_set = fire && (mode_q == IRQ_LEVEL) && irq_q && !ack_i;
  end

  // Config write has priority over restart, which has priority over normal
  // operation. Overrun survives a config write but not a restart.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= IRQ_OFF;
      period_q <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (cfg_we_i) begin
      mode_q   <= cfg_mode_i;
      period_q <= cfg_period_i;
      cnt_q    <= cfg_period_i;
      pcnt_q   <= '0;
      irq_q    <= 1'b0;
      if (clear_i) ovr_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= period_q;
      pcnt_q <= '0;
      irq_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (active) cnt_q <= fire ? period_q : cnt_q - 1'b1;
      if (fire) begin
        irq_q <= 1'b1;
        if (mode_q == IRQ_PULSE) pcnt_q <= PW'(PULSE_CYCLES);
      end else if ((mode_q == IRQ_PULSE) && (pcnt_q != '0)) begin
        pcnt_q <= pcnt_q - 1'b1;
        if (pcnt_q == PW'(1)) irq_q <= 1'b0;
      end else if ((mode_q == IRQ_LEVEL) && ack_i) begin
        irq_q <= 1'b0;
      end
      if (ovr_set) ovr_q <= 1'b1;
    end
  end

  assign irq_o     = irq_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/irq_stim_gen.sv
// Reset sequencer and interrupt stimulus generator for the CPU testbench.
// Holds the CPU in reset for RESET_CYCLES cycles, then lets NUM_IRQ channels
// fire on their own periodic schedules.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   sw_rst_i         synchronous restart of the reset sequence
//   cfg_we_i         config write strobe; cfg_ch_i/cfg_mode_i/cfg_period_i
//   ack_i, ack_id_i  CPU acknowledge and the channel it targets
//   rst_cpu_o        active-high CPU reset
//   irq_o            interrupt lines
//   overrun_o        sticky per-channel overrun flags
//   running_o        high in RUN
module irq_stim_gen
  import irq_stim_gen_pkg::*;
#(
  parameter int NUM_IRQ      = 32,
  parameter int RESET_CYCLES = 10,
  parameter int CNT_W        = 16,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             sw_rst_i,
  input  logic                             cfg_we_i,
  input  logic [ch_width(NUM_IRQ)-1:0]     cfg_ch_i,
  input  logic [1:0]                       cfg_mode_i,
  input  logic [CNT_W-1:0]                 cfg_period_i,
  input  logic                             ack_i,
  input  logic [ch_width(NUM_IRQ)-1:0]     ack_id_i,
  output logic                             rst_cpu_o,
  output logic [NUM_IRQ-1:0]               irq_o,
  output logic [NUM_IRQ-1:0]               overrun_o,
  output logic                             running_o
);

  localparam int CH_W = ch_width(NUM_IRQ);
  localparam int RCW  = $clog2(RESET_CYCLES + 1);

  gen_state_t     state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  irq_mode_t      cfg_mode;
  logic           run;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GEN_RESET;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next state: RESET_CYCLES edges in RESET, then RUN; sw_rst_i restarts the count.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      GEN_RESET: begin
        if (sw_rst_i) begin
          rcnt_d = '0;
        end else if (rcnt_q == RCW'(RESET_CYCLES - 1)) begin
          state_d = GEN_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      GEN_RUN: begin
        if (sw_rst_i) begin
          state_d = GEN_RESET;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = GEN_RESET;
        rcnt_d  = '0;
      end
    endcase
  end

  // Outputs decode the state register only, so both edges are glitch-free
  // and rst_cpu_o falls on the same edge running_o rises.
  always_comb begin
    rst_cpu_o = (state_q == GEN_RESET);
    running_o = (state_q == GEN_RUN);
  end

  // The unused mode encoding behaves as OFF so a channel cannot latch high.
  always_comb begin
    cfg_mode = (cfg_mode_i == 2'd3) ? IRQ_OFF : irq_mode_t'(cfg_mode_i);
  end

  assign run = (state_q == GEN_RUN);

  // Out-of-range channel ids match no instance, so those writes/acks vanish.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
    irq_stim_channel #(
      .CNT_W        (CNT_W),
      .PULSE_CYCLES (PULSE_CYCLES)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .run_i        (run),
      .clear_i      (sw_rst_i),
      .cfg_we_i     (cfg_we_i && (cfg_ch_i == CH_W'(i))),
      .cfg_mode_i   (cfg_mode),
      .cfg_period_i (cfg_period_i),
      .ack_i        (ack_i && (ack_id_i == CH_W'(i))),
      .irq_o        (irq_o[i]),
      .overrun_o    (overrun_o[i])
    );
  end

endmodule
